// File: rtl/freq_meas_sched.sv
// freq_meas_sched
//   Round-robin scheduler that shares one gated frequency counter among
//   N_CH oscillator channels. For each enabled channel it routes the channel
//   to the counter, lets the input settle, pulses a start, and holds the
//   counting gate open for GATE_LEN cycles. It then waits for the counter
//   result and offers it to the UART framer over a valid/ready handshake.
//
// Ports
//   i_clk_ocxo            OCXO reference clock (the only clock)
//   i_rst                 asynchronous reset, active high
//   i_en                  scan enable (level)
//   i_ch_mask[N_CH]       channel i is part of the scan when bit i is set
//   o_ch_sel[CH_W]        channel currently routed to the counter
//   o_meas_start          one-cycle pulse that clears and arms the counter
//   o_gate                counting window
//   i_meas_done           counter result valid (synchronised one-cycle pulse)
//   i_meas_cnt/err        counter value / counter error value
//   o_tx_valid            result record offered to the framer
//   i_tx_ready            framer accepts the record
//   o_tx_ch/cnt/err       latched record fields
//   o_tx_tmo              record is a timeout record
//   o_busy                scheduler not idle
//   o_scan_done           one-cycle pulse after the highest enabled channel
//                         has been reported
//
// Build option
//   FMS_TIMEOUT_EN  when defined, WAIT gives up after TIMEOUT cycles and
//                   reports a timeout record (cnt=0, err=all ones, tmo=1).
//                   When undefined, WAIT waits forever and o_tx_tmo is 0.
//
// State    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | scan stopped, waiting for enable and a non-empty mask
// S_SELECT | pick next enabled channel after the pointer, route it
// S_SETTLE | SETTLE cycles to let the routed input settle
// S_START  | one-cycle start pulse to the counter
// S_GATE   | gate open for GATE_LEN cycles
// S_WAIT   | waiting for the counter result (or timeout)
// S_REPORT | record offered to the framer until accepted
// S_NEXT   | end-of-scan check, then continue or stop

module freq_meas_sched #(
  parameter int N_CH     = 15,
  parameter int CH_W     = 4,
  parameter int CNT_W    = 25,
  parameter int GATE_LEN = 16000000,
  parameter int SETTLE   = 4,
  parameter int TIMEOUT  = 1024
) (
  input  logic              i_clk_ocxo,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic [N_CH-1:0]   i_ch_mask,
  output logic [CH_W-1:0]   o_ch_sel,
  output logic              o_meas_start,
  output logic              o_gate,
  input  logic              i_meas_done,
  input  logic [CNT_W-1:0]  i_meas_cnt,
  input  logic [CNT_W-1:0]  i_meas_err,
  output logic              o_tx_valid,
  input  logic              i_tx_ready,
  output logic [CH_W-1:0]   o_tx_ch,
  output logic [CNT_W-1:0]  o_tx_cnt,
  output logic [CNT_W-1:0]  o_tx_err,
  output logic              o_tx_tmo,
  output logic              o_busy,
  output logic              o_scan_done
);

  localparam int GW = $clog2(GATE_LEN + 1);
  localparam int SW = $clog2(SETTLE + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_SETTLE, S_START, S_GATE, S_WAIT, S_REPORT, S_NEXT
  } state_t;

  state_t           r_state, w_next;
  logic [CH_W-1:0]  r_ptr;
  logic [CH_W-1:0]  r_ch_sel;
  logic [SW-1:0]    r_settle_cnt;
  logic [GW-1:0]    r_gate_cnt;
  logic [CH_W-1:0]  r_tx_ch;
  logic [CNT_W-1:0] r_tx_cnt;
  logic [CNT_W-1:0] r_tx_err;

  logic             w_any;
  logic             w_found_hi;
  logic [CH_W-1:0]  w_hi;
  logic [CH_W-1:0]  w_lo;
  logic [CH_W-1:0]  w_next_ch;
  logic             w_done_hit;
  logic             w_tmo_hit;

`ifdef FMS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_tmo_cnt;
  logic          r_tx_tmo;
`else
  logic          w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT > 0);
`endif

  assign w_any = |i_ch_mask;

  // Scan from the top down so the last hit is the lowest index: w_hi ends
  // as the lowest set bit above the pointer, w_lo as the lowest set bit
  // overall (the wrap-around choice, which includes the pointer itself).
  always_comb begin
    w_found_hi = 1'b0;
    w_hi       = '0;
    w_lo       = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (i_ch_mask[i]) begin
        w_lo = CH_W'(i);
        if (CH_W'(i) > r_ptr) begin
          w_hi       = CH_W'(i);
          w_found_hi = 1'b1;
        end
      end
    end
    w_next_ch = w_found_hi ? w_hi : w_lo;
  end

  assign w_done_hit = i_en & i_meas_done;
`ifdef FMS_TIMEOUT_EN
  assign w_tmo_hit  = i_en & ~i_meas_done & (r_tmo_cnt == '0);
`else
  assign w_tmo_hit  = 1'b0;
`endif

  always_ff @(posedge i_clk_ocxo or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (i_en && w_any) w_next = S_SELECT;
      S_SELECT: w_next = S_SETTLE;
      S_SETTLE: begin
        if (!i_en)                    w_next = S_IDLE;
        else if (r_settle_cnt == '0)  w_next = S_START;
      end
      S_START:  w_next = i_en ? S_GATE : S_IDLE;
      S_GATE: begin
        if (!i_en)                  w_next = S_IDLE;
        else if (r_gate_cnt == '0)  w_next = S_WAIT;
      end
      S_WAIT: begin
        if (!i_en)                        w_next = S_IDLE;
        else if (w_done_hit || w_tmo_hit) w_next = S_REPORT;
      end
      S_REPORT: if (i_tx_ready) w_next = S_NEXT;
      S_NEXT:   w_next = (i_en && w_any) ? S_SELECT : S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk_ocxo or posedge i_rst) begin
    if (i_rst) begin
      r_ptr        <= CH_W'(N_CH - 1);
      r_ch_sel     <= '0;
      r_settle_cnt <= '0;
      r_gate_cnt   <= '0;
      r_tx_ch      <= '0;
      r_tx_cnt     <= '0;
      r_tx_err     <= '0;
`ifdef FMS_TIMEOUT_EN
      r_tmo_cnt    <= '0;
      r_tx_tmo     <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_SELECT: begin
          r_ch_sel     <= w_next_ch;
          r_ptr        <= w_next_ch;
          r_settle_cnt <= SW'(SETTLE - 1);
        end
        S_SETTLE: if (r_settle_cnt != '0) r_settle_cnt <= r_settle_cnt - 1'b1;
        S_START:  r_gate_cnt <= GW'(GATE_LEN - 1);
        S_GATE: begin
          if (r_gate_cnt != '0) r_gate_cnt <= r_gate_cnt - 1'b1;
`ifdef FMS_TIMEOUT_EN
          r_tmo_cnt <= TW'(TIMEOUT - 1);
`endif
        end
        S_WAIT: begin
          if (w_done_hit) begin
            r_tx_ch  <= r_ptr;
            r_tx_cnt <= i_meas_cnt;
            r_tx_err <= i_meas_err;
`ifdef FMS_TIMEOUT_EN
            r_tx_tmo <= 1'b0;
          end else if (w_tmo_hit) begin
            r_tx_ch  <= r_ptr;
            r_tx_cnt <= '0;
            r_tx_err <= {CNT_W{1'b1}};
            r_tx_tmo <= 1'b1;
          end else if (r_tmo_cnt != '0) begin
            r_tmo_cnt <= r_tmo_cnt - 1'b1;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  // Control outputs decode straight from the state register so an async
  // reset drops the gate, valid and busy in the same instant.
  assign o_ch_sel     = r_ch_sel;
  assign o_meas_start = (r_state == S_START);
  assign o_gate       = (r_state == S_GATE);
  assign o_tx_valid   = (r_state == S_REPORT);
  assign o_busy       = (r_state != S_IDLE);
  assign o_scan_done  = (r_state == S_NEXT) & ~w_found_hi & i_ch_mask[r_ptr];
  assign o_tx_ch      = r_tx_ch;
  assign o_tx_cnt     = r_tx_cnt;
  assign o_tx_err     = r_tx_err;
`ifdef FMS_TIMEOUT_EN
  assign o_tx_tmo     = r_tx_tmo;
`else
  assign o_tx_tmo     = 1'b0;
`endif

endmodule
